// File: rtl/mdu_pkg.sv
// Shared types and constants for the iterative multiply/divide unit.
package mdu_pkg;

    // Operand and HI/LO register width; the datapath is written for 32 only.
    localparam int WIDTH = 32;

    // Operation encoding as presented on the MDU_op port.
    typedef enum logic [1:0] {
        MULT  = 2'b00,
        MULTU = 2'b01,
        DIV   = 2'b10,
        DIVU  = 2'b11
    } mdu_op_t;

    // Controller states: waiting, iterating, sign fix-up and writeback.
    typedef enum logic [1:0] {
        IDLE = 2'b00,
        RUN  = 2'b01,
        FIX  = 2'b10
    } mdu_state_t;

endpackage

// File: rtl/mul_div_unit.sv
// Iterative MULT/MULTU/DIV/DIVU unit owning the architectural HI/LO registers.
// Both operations work on operand magnitudes and share one 64-bit accumulator;
// signs are re-applied in the FIX cycle.
module mul_div_unit
    import mdu_pkg::*;
#(
    parameter int WIDTH = mdu_pkg::WIDTH
) (
    input  logic             clk,
    input  logic             SYS_reset_n,
    input  logic             MDU_start,
    input  logic [1:0]       MDU_op,
    input  logic [WIDTH-1:0] MDU_operand1,
    input  logic [WIDTH-1:0] MDU_operand2,
    input  logic             MDU_write_hi,
    input  logic             MDU_write_lo,
    input  logic [WIDTH-1:0] MDU_write_data,
    output logic             MDU_busy,
    output logic             MDU_done,
    output logic [WIDTH-1:0] MDU_hi,
    output logic [WIDTH-1:0] MDU_lo
);

    localparam int CNT_W = $clog2(WIDTH);

    mdu_state_t         r_state;
    mdu_state_t         w_state_next;
    mdu_op_t            r_op;
    mdu_op_t            w_op_in;
    logic               r_sign1;
    logic               r_sign2;
    logic               r_divzero;
    logic               r_done;
    logic [CNT_W-1:0]   r_cnt;
    logic [WIDTH-1:0]   r_a;
    logic [WIDTH-1:0]   r_b;
    logic [2*WIDTH-1:0] r_acc;
    logic [WIDTH-1:0]   r_hi;
    logic [WIDTH-1:0]   r_lo;

    logic               w_in_signed;
    logic [WIDTH-1:0]   w_mag1;
    logic [WIDTH-1:0]   w_mag2;
    logic               w_is_div;
    logic [WIDTH:0]     w_sum;
    logic [WIDTH:0]     w_rem_shift;
    logic [WIDTH-1:0]   w_diff;
    logic               w_ge;
    logic [2*WIDTH-1:0] w_acc_next;
    logic [2*WIDTH-1:0] w_prod;
    logic [WIDTH-1:0]   w_quot;
    logic [WIDTH-1:0]   w_rem;
    logic [WIDTH-1:0]   w_res_hi;
    logic [WIDTH-1:0]   w_res_lo;
    logic               w_busy;

    // Operand magnitudes at start; negating 0x80000000 leaves 2^31 as unsigned.
    always_comb begin
        w_op_in     = mdu_op_t'(MDU_op);
        w_in_signed = (w_op_in == MULT) || (w_op_in == DIV);
        w_mag1      = (w_in_signed && MDU_operand1[WIDTH-1]) ? -MDU_operand1 : MDU_operand1;
        w_mag2      = (w_in_signed && MDU_operand2[WIDTH-1]) ? -MDU_operand2 : MDU_operand2;
    end

    // One iteration: shift-add (multiplier LSB-first) or restoring divide (dividend MSB-first).
    always_comb begin
        w_is_div    = r_op[1];
        w_sum       = {1'b0, r_acc[2*WIDTH-1:WIDTH]} + (r_b[0] ? {1'b0, r_a} : '0);
        w_rem_shift = {r_acc[2*WIDTH-1:WIDTH], r_a[WIDTH-1]};
        w_ge        = (w_rem_shift >= {1'b0, r_b});
        w_diff      = w_rem_shift[WIDTH-1:0] - r_b;
        if (w_is_div) begin
            w_acc_next = {(w_ge ? w_diff : w_rem_shift[WIDTH-1:0]), r_acc[WIDTH-2:0], w_ge};
        end else begin
            w_acc_next = {w_sum, r_acc[WIDTH-1:1]};
        end
    end

    // Sign fix-up and HI/LO selection used in the FIX cycle.
    always_comb begin
        w_prod = ((r_op == MULT) && (r_sign1 ^ r_sign2)) ? -r_acc : r_acc;
        w_quot = ((r_op == DIV) && (r_sign1 ^ r_sign2)) ? -r_acc[WIDTH-1:0] : r_acc[WIDTH-1:0];
        w_rem  = ((r_op == DIV) && r_sign1) ? -r_acc[2*WIDTH-1:WIDTH] : r_acc[2*WIDTH-1:WIDTH];
        if (w_is_div) begin
            w_res_hi = w_rem;
            w_res_lo = r_divzero ? '1 : w_quot;
        end else begin
            w_res_hi = w_prod[2*WIDTH-1:WIDTH];
            w_res_lo = w_prod[WIDTH-1:0];
        end
    end

    // State, counter and iteration datapath registers.
    always_ff @(posedge clk or negedge SYS_reset_n) begin
        if (!SYS_reset_n) begin
            r_state   <= IDLE;
            r_op      <= MULT;
            r_sign1   <= 1'b0;
            r_sign2   <= 1'b0;
            r_divzero <= 1'b0;
            r_done    <= 1'b0;
            r_cnt     <= '0;
            r_a       <= '0;
            r_b       <= '0;
            r_acc     <= '0;
        end else begin
            r_state <= w_state_next;
            r_done  <= (r_state == FIX);
            case (r_state)
                IDLE: begin
                    if (MDU_start) begin
                        r_op      <= w_op_in;
                        r_sign1   <= w_in_signed & MDU_operand1[WIDTH-1];
                        r_sign2   <= w_in_signed & MDU_operand2[WIDTH-1];
                        r_divzero <= MDU_op[1] && (MDU_operand2 == '0);
                        r_a       <= w_mag1;
                        r_b       <= w_mag2;
                        r_acc     <= '0;
                        r_cnt     <= '0;
                    end
                end
                RUN: begin
                    r_acc <= w_acc_next;
                    r_cnt <= r_cnt + 1'b1;
                    if (w_is_div) begin
                        r_a <= r_a << 1;
                    end else begin
                        r_b <= r_b >> 1;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    // Next-state selection; RUN lasts exactly WIDTH iterations.
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            IDLE:    if (MDU_start) w_state_next = RUN;
            RUN:     if (r_cnt == CNT_W'(WIDTH - 1)) w_state_next = FIX;
            FIX:     w_state_next = IDLE;
            default: w_state_next = IDLE;
        endcase
    end

    // Busy covers every non-IDLE cycle so the hazard logic can stall HI/LO readers.
    always_comb begin
        w_busy = (r_state != IDLE);
    end

    // HI/LO: result writeback in FIX, otherwise MTHI/MTLO only when idle and not starting.
    always_ff @(posedge clk or negedge SYS_reset_n) begin
        if (!SYS_reset_n) begin
            r_hi <= '0;
            r_lo <= '0;
        end else if (r_state == FIX) begin
            r_hi <= w_res_hi;
            r_lo <= w_res_lo;
        end else if ((r_state == IDLE) && !MDU_start) begin
            if (MDU_write_hi) r_hi <= MDU_write_data;
            if (MDU_write_lo) r_lo <= MDU_write_data;
        end
    end

    assign MDU_busy = w_busy;
    assign MDU_done = r_done;
    assign MDU_hi   = r_hi;
    assign MDU_lo   = r_lo;

endmodule

// File: tb/tb_mul_div_unit.sv
// Self-checking bench for mul_div_unit: a vector table plus random ops feed a
// scoreboard of expected HI/LO, and hand sequences cover in-flight writes,
// MTLO/MTHI in idle and reset during an operation.
module tb_mul_div_unit;

    logic        clk;
    logic        SYS_reset_n;
    logic        MDU_start;
    logic [1:0]  MDU_op;
    logic [31:0] MDU_operand1;
    logic [31:0] MDU_operand2;
    logic        MDU_write_hi;
    logic        MDU_write_lo;
    logic [31:0] MDU_write_data;
    logic        MDU_busy;
    logic        MDU_done;
    logic [31:0] MDU_hi;
    logic [31:0] MDU_lo;

    typedef struct {
        logic [1:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] expHi;
        logic [31:0] expLo;
        string       name;
    } vec_t;

    typedef struct {
        logic [31:0] hi;
        logic [31:0] lo;
        string       name;
    } exp_t;

    vec_t        vecs[$];
    exp_t        sbQ[$];
    int          passCount = 0;
    int          totalCount = 0;
    logic [31:0] expHiReg = '0;
    logic [31:0] expLoReg = '0;

    mul_div_unit #(.WIDTH(32)) dut (
        .clk           (clk),
        .SYS_reset_n   (SYS_reset_n),
        .MDU_start     (MDU_start),
        .MDU_op        (MDU_op),
        .MDU_operand1  (MDU_operand1),
        .MDU_operand2  (MDU_operand2),
        .MDU_write_hi  (MDU_write_hi),
        .MDU_write_lo  (MDU_write_lo),
        .MDU_write_data(MDU_write_data),
        .MDU_busy      (MDU_busy),
        .MDU_done      (MDU_done),
        .MDU_hi        (MDU_hi),
        .MDU_lo        (MDU_lo)
    );

    // Free-running 10 ns clock.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Hard stop in case something stalls far beyond any expected run length.
    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    function automatic vec_t mkVec(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                                   input logic [31:0] eh, input logic [31:0] el, input string name);
        vec_t v;
        v.op = op; v.a = a; v.b = b; v.expHi = eh; v.expLo = el; v.name = name;
        return v;
    endfunction

    task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
        totalCount++;
        if (act === exp) passCount++;
        else $display("[TB] FAIL %s: got %h, required %h", name, act, exp);
    endtask

    // Drives a start for one cycle window and records the expected result.
    task automatic applyStimulus(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                                 input logic [31:0] eh, input logic [31:0] el, input string name);
        exp_t e;
        @(negedge clk);
        MDU_op       = op;
        MDU_operand1 = a;
        MDU_operand2 = b;
        MDU_start    = 1'b1;
        e.hi = eh; e.lo = el; e.name = name;
        sbQ.push_back(e);
    endtask

    // Waits (bounded) for done, counting busy cycles; optionally disturbs inputs mid-run.
    task automatic waitDone(input int disturbFrom, output bit seen, output int cyc, output int busyCyc,
                            output logic [31:0] hiFirst, output logic [31:0] hiMid);
        seen = 1'b0; cyc = 0; busyCyc = 0; hiFirst = '0; hiMid = '0;
        while (!seen && cyc < 100) begin
            @(negedge clk);
            cyc++;
            if (cyc == 1)  hiFirst = MDU_hi;
            if (cyc == 20) hiMid = MDU_hi;
            if (MDU_busy) busyCyc++;
            if (MDU_done) seen = 1'b1;
            if (disturbFrom > 0 && cyc >= disturbFrom && cyc < disturbFrom + 4) begin
                MDU_start      = 1'b1;
                MDU_op         = 2'b10;
                MDU_operand1   = $urandom;
                MDU_operand2   = $urandom;
                MDU_write_hi   = 1'b1;
                MDU_write_data = 32'hAAAA5555;
            end else begin
                MDU_start    = 1'b0;
                MDU_write_hi = 1'b0;
                MDU_write_lo = 1'b0;
            end
        end
    endtask

    // Pops the scoreboard and compares HI/LO, latency, busy length and the one-cycle done pulse.
    task automatic checkOutput(input bit seen, input int cyc, input int busyCyc);
        exp_t e;
        if (sbQ.size() == 0) begin
            check32("scoreboard_empty", 32'd0, 32'd1);
            return;
        end
        e = sbQ.pop_front();
        if (!seen) begin
            check32({e.name, "_done_timeout"}, 32'd0, 32'd1);
            return;
        end
        check32({e.name, "_hi"}, MDU_hi, e.hi);
        check32({e.name, "_lo"}, MDU_lo, e.lo);
        check32({e.name, "_latency"}, 32'(cyc), 32'd34);
        check32({e.name, "_busy_cycles"}, 32'(busyCyc), 32'd33);
        expHiReg = e.hi;
        expLoReg = e.lo;
        @(negedge clk);
        check32({e.name, "_done_pulse_width"}, {31'd0, MDU_done}, 32'd0);
    endtask

    task automatic runOne(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                          input logic [31:0] eh, input logic [31:0] el, input string name);
        bit seen; int cyc; int busyCyc; logic [31:0] h1; logic [31:0] hm;
        applyStimulus(op, a, b, eh, el, name);
        waitDone(0, seen, cyc, busyCyc, h1, hm);
        checkOutput(seen, cyc, busyCyc);
    endtask

    // Main sequence: reset, vector table, random ops, then the hand-written corner cases.
    initial begin
        bit          seen;
        int          cyc;
        int          busyCyc;
        logic [31:0] h1;
        logic [31:0] hm;
        logic [31:0] ra;
        logic [31:0] rb;
        logic [63:0] prod;
        longint      sprod;
        bit          doneAfterReset;

        SYS_reset_n    = 1'b0;
        MDU_start      = 1'b0;
        MDU_op         = 2'b00;
        MDU_operand1   = '0;
        MDU_operand2   = '0;
        MDU_write_hi   = 1'b0;
        MDU_write_lo   = 1'b0;
        MDU_write_data = '0;

        repeat (2) @(negedge clk);
        check32("reset_busy", {31'd0, MDU_busy}, 32'd0);
        check32("reset_done", {31'd0, MDU_done}, 32'd0);
        check32("reset_hi", MDU_hi, 32'd0);
        check32("reset_lo", MDU_lo, 32'd0);
        SYS_reset_n = 1'b1;

        vecs.push_back(mkVec(2'b00, 32'hFFFFFFFF, 32'h00000005, 32'hFFFFFFFF, 32'hFFFFFFFB, "mult_m1x5"));
        vecs.push_back(mkVec(2'b01, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001, "multu_max"));
        vecs.push_back(mkVec(2'b00, 32'h80000000, 32'h80000000, 32'h40000000, 32'h00000000, "mult_min_sq"));
        vecs.push_back(mkVec(2'b00, 32'h00000007, 32'hFFFFFFFD, 32'hFFFFFFFF, 32'hFFFFFFEB, "mult_7xm3"));
        vecs.push_back(mkVec(2'b01, 32'h12345678, 32'h00000010, 32'h00000001, 32'h23456780, "multu_shift"));
        vecs.push_back(mkVec(2'b10, 32'hFFFFFFF9, 32'h00000002, 32'hFFFFFFFF, 32'hFFFFFFFD, "div_m7_2"));
        vecs.push_back(mkVec(2'b11, 32'h00000007, 32'h00000002, 32'h00000001, 32'h00000003, "divu_7_2"));
        vecs.push_back(mkVec(2'b10, 32'h12345678, 32'h00000000, 32'h12345678, 32'hFFFFFFFF, "div_by_zero"));
        vecs.push_back(mkVec(2'b10, 32'hFFFFFF9C, 32'h00000000, 32'hFFFFFF9C, 32'hFFFFFFFF, "div_neg_by_zero"));
        vecs.push_back(mkVec(2'b10, 32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000, "div_overflow"));
        vecs.push_back(mkVec(2'b10, 32'h00000064, 32'hFFFFFFF9, 32'h00000002, 32'hFFFFFFF2, "div_100_m7"));
        vecs.push_back(mkVec(2'b11, 32'hFFFFFFFF, 32'h00000010, 32'h0000000F, 32'h0FFFFFFF, "divu_big"));

        foreach (vecs[i]) begin
            runOne(vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].expHi, vecs[i].expLo, vecs[i].name);
        end

        for (int i = 0; i < 3; i++) begin
            ra = $urandom; rb = $urandom;
            prod = 64'(ra) * 64'(rb);
            runOne(2'b01, ra, rb, prod[63:32], prod[31:0], "rand_multu");
            sprod = longint'($signed(ra)) * longint'($signed(rb));
            prod = 64'(sprod);
            runOne(2'b00, ra, rb, prod[63:32], prod[31:0], "rand_mult");
            rb = $urandom_range(1, 32'h0000FFFF);
            runOne(2'b11, ra, rb, ra % rb, ra / rb, "rand_divu");
        end

        // In-flight start, MTHI and operand changes must not affect the running op.
        applyStimulus(2'b01, 32'h00012345, 32'h00000100, 32'h00000000, 32'h01234500, "inflight");
        h1 = expHiReg;
        waitDone(5, seen, cyc, busyCyc, hm, hm);
        check32("inflight_hi_mid_run", hm, h1);
        checkOutput(seen, cyc, busyCyc);

        // MTLO in idle: LO updates after one edge, HI untouched.
        @(negedge clk);
        MDU_write_lo   = 1'b1;
        MDU_write_data = 32'h00001234;
        @(negedge clk);
        MDU_write_lo = 1'b0;
        expLoReg = 32'h00001234;
        check32("mtlo_lo", MDU_lo, expLoReg);
        check32("mtlo_hi", MDU_hi, expHiReg);

        // Start with a simultaneous MTHI: the start wins and MTHI is dropped.
        h1 = expHiReg;
        applyStimulus(2'b01, 32'h00000002, 32'h00000003, 32'h00000000, 32'h00000006, "start_vs_mthi");
        MDU_write_hi   = 1'b1;
        MDU_write_data = 32'hDEADBEEF;
        waitDone(0, seen, cyc, busyCyc, hm, ra);
        check32("start_vs_mthi_hi_dropped", hm, h1);
        checkOutput(seen, cyc, busyCyc);

        // Reset in the middle of RUN aborts with no done pulse.
        @(negedge clk);
        MDU_op = 2'b01; MDU_operand1 = 32'hFFFFFFFF; MDU_operand2 = 32'hFFFFFFFF; MDU_start = 1'b1;
        @(negedge clk);
        MDU_start = 1'b0;
        repeat (9) @(negedge clk);
        SYS_reset_n = 1'b0;
        #1;
        check32("midreset_busy", {31'd0, MDU_busy}, 32'd0);
        check32("midreset_done", {31'd0, MDU_done}, 32'd0);
        check32("midreset_hi", MDU_hi, 32'd0);
        check32("midreset_lo", MDU_lo, 32'd0);
        @(negedge clk);
        SYS_reset_n = 1'b1;
        doneAfterReset = 1'b0;
        repeat (40) begin
            @(negedge clk);
            if (MDU_done) doneAfterReset = 1'b1;
        end
        check32("midreset_no_done", {31'd0, doneAfterReset}, 32'd0);
        check32("midreset_idle_after", {31'd0, MDU_busy}, 32'd0);
        expHiReg = '0;
        expLoReg = '0;

        runOne(2'b01, 32'h00000003, 32'h00000004, 32'h00000000, 32'h0000000C, "multu_3x4_after_reset");

        $display("%0d/%0d checks passed", passCount, totalCount);
        $finish;
    end

endmodule

// File: doc/mul_div_unit.md
# mul_div_unit

Iterative multiply/divide unit for the MIPS core, sitting directly downstream of the register file. It consumes the two register read-port values (rs, rt) in the execute stage and runs MULT, MULTU, DIV and DIVU over 32 iterations. It holds the architectural HI/LO registers, which MFHI/MFLO read and MTHI/MTLO write. It raises `MDU_busy` so the hazard logic can stall any later HI/LO access.

## Interface

Parameters:
- `WIDTH`, 32: operand/HI/LO width. Only 32 is supported; the iteration counter is sized `$clog2(WIDTH)`.

Ports:
- `clk`  in  1  clock; all state updates on posedge.
- `SYS_reset_n`  in  1  asynchronous, active-low reset.
- `MDU_start`  in  1  starts an operation; sampled only in IDLE.
- `MDU_op`  in  2  operation select: 00 MULT, 01 MULTU, 10 DIV, 11 DIVU.
- `MDU_operand1`  in  WIDTH  rs value (multiplicand / dividend).
- `MDU_operand2`  in  WIDTH  rt value (multiplier / divisor).
- `MDU_write_hi`  in  1  MTHI strobe.
- `MDU_write_lo`  in  1  MTLO strobe.
- `MDU_write_data`  in  WIDTH  data for MTHI/MTLO.
- `MDU_busy`  out  1  high whenever the state is not IDLE.
- `MDU_done`  out  1  one-cycle pulse; HI/LO hold the new result.
- `MDU_hi`  out  WIDTH  HI register.
- `MDU_lo`  out  WIDTH  LO register.

Reset values: `MDU_busy`=0, `MDU_done`=0, `MDU_hi`=0, `MDU_lo`=0, state=IDLE.

## Operation

- States are IDLE, RUN and FIX.
- **IDLE + `MDU_start`:**
  - Latch the op and the operand signs.
  - Latch the operand magnitudes. For signed ops (MULT/DIV), a negative operand is replaced by its two's-complement negation. 0x80000000 maps to the unsigned value 2^31.
  - Clear the 64-bit accumulator and the counter, then go to RUN.
- **RUN, multiply:** one shift-add step per cycle, LSB-first on the multiplier. This yields a 64-bit unsigned product after 32 steps.
- **RUN, divide:** one restoring-division step per cycle, MSB-first. This yields a 32-bit quotient and a 32-bit remainder.
- **RUN exit:** when the counter reaches `WIDTH-1`, go to FIX.
- **FIX, multiply:** for MULT with differing operand signs, negate the 64-bit product. Then HI = product[63:32], LO = product[31:0].
- **FIX, divide:**
  - For DIV, negate the quotient if the operand signs differ; negate the remainder if the dividend was negative.
  - Then LO = quotient, HI = remainder.
  - Divide by zero: LO = 0xFFFFFFFF, HI = the original `MDU_operand1`. The operation still takes the full latency.
  - Signed 0x80000000 / 0xFFFFFFFF gives LO = 0x80000000, HI = 0, which falls out of the magnitude datapath with no special case.
- **FIX exit:** go to IDLE and assert `MDU_done` for the following cycle.
- **MTHI/MTLO:** in IDLE with no start, write HI and/or LO at the next edge. Both strobes may be asserted together.
- **Ignored inputs:**
  - `MDU_start` and MTHI/MTLO strobes are ignored while busy.
  - In IDLE, if `MDU_start` and a write strobe are asserted in the same cycle, start wins and the write is dropped.
- HI/LO change only at the FIX edge or at an accepted MTHI/MTLO edge. Between those points they hold their previous values.

## Timing

- Edge E0 samples the start; `MDU_busy` is high from E0 through E33, i.e. 33 cycles.
- E1–E32 are the 32 RUN iterations. E33 is FIX and writes HI/LO.
- `MDU_done` is high for exactly the cycle after E33, while `MDU_busy` is 0 and the new HI/LO are visible.
- A new start can be accepted in that same done cycle, so back-to-back operations are 34 cycles apart.
- Operands are needed only in the E0 cycle; later changes have no effect.
- MTHI/MTLO latency: 1 edge.
- `SYS_reset_n` low at any point, including mid-RUN, immediately returns the block to reset values. No `MDU_done` is produced for an aborted operation.

## Structure

- Package `mdu_pkg`:
  - `WIDTH` constant.
  - `mdu_op_t` enum: MULT, MULTU, DIV, DIVU.
  - `mdu_state_t` enum: IDLE, RUN, FIX.
- Single module `mul_div_unit`, with no sub-module. The multiply and divide iterations share the 64-bit accumulator register and the counter.
- The module has one always block for state, counter and datapath, one for HI/LO, and combinational next-step logic.

## Test plan

- MULT 0xFFFFFFFF × 0x00000005 -> HI=0xFFFFFFFF, LO=0xFFFFFFFB; `MDU_done` exactly 34 edges after start; `MDU_busy` high for 33 cycles.
- MULTU 0xFFFFFFFF × 0xFFFFFFFF -> HI=0xFFFFFFFE, LO=0x00000001. MULT 0x80000000 × 0x80000000 -> HI=0x40000000, LO=0.
- DIV 0xFFFFFFF9 / 0x00000002 (-7/2) -> LO=0xFFFFFFFD, HI=0xFFFFFFFF. DIVU 7/2 -> LO=3, HI=1.
- DIV 0x12345678 / 0 -> LO=0xFFFFFFFF, HI=0x12345678. DIV 0x80000000 / 0xFFFFFFFF -> LO=0x80000000, HI=0.
- In-flight and IDLE writes:
  - During RUN: a second `MDU_start`, MTHI 0xAAAA5555 and operand changes are all ignored; the result matches the first op.
  - In IDLE: MTLO 0x00001234 -> LO=0x00001234 after 1 edge, HI unchanged.
  - In IDLE: start and MTHI together -> start taken, MTHI dropped.
- Reset mid-operation and recovery:
  - `SYS_reset_n` pulsed low at RUN iteration 10 -> busy=0, HI=LO=0, no `MDU_done`.
  - A subsequent MULTU 3×4 -> LO=12, HI=0.
